bitstream_self_writer: RTL

- Hardware loader that drives the fabric configuration port `SelfWriteData`/`SelfWriteStrobe` of `eFPGA_top`.
- Accepts a byte stream (valid/ready) from flash, SPI or ROM and packs it big-endian into 32-bit words.
- Issues one strobe per word using the fabric's required pacing: data stable before strobe, single-cycle strobe, idle gap after.
- Sits between the boot-source reader and `eFPGA_top`. It replaces testbench-driven configuration in silicon and emulation builds.

---
 rtl/fabulous_cfg_pkg.sv | 17 +
 rtl/bitstream_self_writer_if.sv | 24 ++
 rtl/cfg_word_packer.sv | 31 +++
 rtl/bitstream_self_writer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fabulous_cfg_pkg.sv
// Shared types and constants for the fabric configuration writer.
package fabulous_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } cfg_wr_state_t;

    localparam logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1;
    localparam int unsigned DEF_PRE_CYCLES  = 2;
    localparam int unsigned DEF_POST_CYCLES = 2;

endpackage

// File: rtl/bitstream_self_writer_if.sv
// Byte-stream input, fabric write port and status of the bitstream self-writer.
interface bitstream_self_writer_if #(
    parameter int unsigned CNT_W = 15
);
    logic             start;
    logic [CNT_W-1:0] length;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic [31:0]      SelfWriteData;
    logic             SelfWriteStrobe;
    logic             busy;
    logic             done;

    modport master (
        output start, length, byte_data, byte_valid,
        input  byte_ready, SelfWriteData, SelfWriteStrobe, busy, done
    );

    modport slave (
        input  start, length, byte_data, byte_valid,
        output byte_ready, SelfWriteData, SelfWriteStrobe, busy, done
    );
endinterface

// File: rtl/cfg_word_packer.sv
// Packs bytes big-endian into a 32-bit word; first byte lands in [31:24].
module cfg_word_packer (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_c,
    output logic        o_complete_c
);
    logic [1:0]  r_idx;
    logic [31:0] r_word;

    // Lane 3-idx equals ~idx for a 2-bit index.
    assign o_word_c     = r_word | (32'(i_byte) << {~r_idx, 3'b000});
    assign o_complete_c = i_load & ((r_idx == 2'd3) | i_last);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clear || o_complete_c) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= o_word_c;
            r_idx  <= r_idx + 2'd1;
        end
    end
endmodule

// File: rtl/bitstream_self_writer.sv
// Loads a byte stream into the fabric via SelfWriteData/SelfWriteStrobe with fixed pacing.
// Optional: BITSTREAM_SYNC_EN suppresses words until SYNC_WORD has been seen.
module bitstream_self_writer
    import fabulous_cfg_pkg::*;
#(
    parameter int unsigned PRE_CYCLES  = DEF_PRE_CYCLES,
    parameter int unsigned POST_CYCLES = DEF_POST_CYCLES,
    parameter int unsigned MAX_BYTES   = 16384
) (
    input  logic                     CLK,
    input  logic                     resetn,
    bitstream_self_writer_if.slave   bus
);
    localparam int unsigned CNT_W    = $clog2(MAX_BYTES + 1);
    localparam int unsigned PACE_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int unsigned PACE_W   = $clog2(PACE_MAX + 1);

    cfg_wr_state_t     r_state;
    logic [CNT_W-1:0]  r_remaining;
    logic [PACE_W-1:0] r_pace;
    logic [31:0]       r_data;
    logic              r_strobe;
    logic              r_byte_ready;
    logic              r_busy;
    logic              r_done;
`ifdef BITSTREAM_SYNC_EN
    logic              r_synced;
`endif

    logic [CNT_W-1:0] w_len;
    logic             w_hs;
    logic             w_last;
    logic             w_clear;
    logic [31:0]      w_word;
    logic             w_complete;

    assign w_len   = (bus.length > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bus.length;
    assign w_hs    = (r_state == ST_FILL) && r_byte_ready && bus.byte_valid;
    assign w_last  = (r_remaining == CNT_W'(1));
    assign w_clear = (r_state == ST_IDLE) && bus.start;

    cfg_word_packer u_packer (
        .CLK          (CLK),
        .resetn       (resetn),
        .i_clear      (w_clear),
        .i_load       (w_hs),
        .i_last       (w_last),
        .i_byte       (bus.byte_data),
        .o_word_c     (w_word),
        .o_complete_c (w_complete)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_pace       <= '0;
            r_data       <= '0;
            r_strobe     <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef BITSTREAM_SYNC_EN
            r_synced     <= 1'b0;
`endif
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_busy      <= 1'b1;
                        r_remaining <= w_len;
`ifdef BITSTREAM_SYNC_EN
                        r_synced    <= 1'b0;
`endif
                        if (w_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_byte_ready <= 1'b1;
                            r_state      <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_hs) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_complete) begin
`ifdef BITSTREAM_SYNC_EN
                            // Words before the sync word are dropped without touching the fabric.
                            if (r_synced || (w_word == SYNC_WORD)) begin
                                r_synced     <= 1'b1;
                                r_data       <= w_word;
                                r_byte_ready <= 1'b0;
                                r_pace       <= PACE_W'(PRE_CYCLES - 1);
                                r_state      <= ST_SETUP;
                            end else if (w_last) begin
                                r_byte_ready <= 1'b0;
                                r_done       <= 1'b1;
                                r_state      <= ST_DONE;
                            end
`else
                            r_data       <= w_word;
                            r_byte_ready <= 1'b0;
                            r_pace       <= PACE_W'(PRE_CYCLES - 1);
                            r_state      <= ST_SETUP;
`endif
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_pace == '0) begin
                        r_strobe <= 1'b1;
                        r_state  <= ST_STROBE;
                    end else begin
                        r_pace <= r_pace - PACE_W'(1);
                    end
                end
                ST_STROBE: begin
                    r_pace  <= PACE_W'(POST_CYCLES - 1);
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_pace != '0) begin
                        r_pace <= r_pace - PACE_W'(1);
                    end else if (r_remaining != '0) begin
                        r_byte_ready <= 1'b1;
                        r_state      <= ST_FILL;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready      = r_byte_ready;
    assign bus.SelfWriteData   = r_data;
    assign bus.SelfWriteStrobe = r_strobe;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
endmodule
